// File: rtl/fp_mac_seq.sv
`default_nettype none
// =============================================================================
// Module      : fp_mac_seq
// Description : Dot-product sequencer for the pipelined FP multiply-accumulate
//               unit: clear, stream operand pairs, drain, hold the result.
// Revision    : 1.0  initial release
// =============================================================================
module fp_mac_seq #(
    parameter int LEN_W      = 16,
    parameter int LATENCY    = 6,
    parameter int CLR_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    output logic             in_ready,
    output logic [31:0]      mac_a,
    output logic [31:0]      mac_b,
    output logic             mac_clr,
    input  logic [31:0]      mac_out,
    output logic             res_valid,
    output logic [31:0]      res_data,
    input  logic             res_ready,
    output logic [15:0]      bubbles
);

    localparam int C_TMR_MAX = (LATENCY > CLR_CYCLES) ? LATENCY : CLR_CYCLES;
    localparam int C_TMR_W   = $clog2(C_TMR_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t               r_state_q,     w_state_d;
    logic [LEN_W-1:0]     r_len_q,       w_len_d;
    logic [LEN_W-1:0]     r_cnt_q,       w_cnt_d;
    logic [C_TMR_W-1:0]   r_tmr_q,       w_tmr_d;
    logic [31:0]          r_mac_a_q,     w_mac_a_d;
    logic [31:0]          r_mac_b_q,     w_mac_b_d;
    logic [31:0]          r_res_data_q,  w_res_data_d;
    logic                 r_res_valid_q, w_res_valid_d;
    logic                 r_in_ready_q,  w_in_ready_d;
    logic                 r_busy_q,      w_busy_d;
    logic                 r_clr_q,       w_clr_d;
    logic [15:0]          r_bubbles_q,   w_bubbles_d;

    logic                 w_hs;
    logic [LEN_W-1:0]     w_cnt_inc;

    // in_ready is a registered decode of the FEED state, so it qualifies the handshake
    assign w_hs      = r_in_ready_q & in_valid;
    assign w_cnt_inc = r_cnt_q + LEN_W'(1);

    always_comb begin
        w_state_d    = r_state_q;
        w_len_d      = r_len_q;
        w_cnt_d      = r_cnt_q;
        w_tmr_d      = r_tmr_q;
        w_mac_a_d    = 32'h0;
        w_mac_b_d    = 32'h0;
        w_res_data_d = r_res_data_q;
        w_bubbles_d  = r_bubbles_q;

        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    w_bubbles_d = 16'h0;
                    if (len != '0) begin
                        w_len_d   = len;
                        w_cnt_d   = '0;
                        w_tmr_d   = C_TMR_W'(CLR_CYCLES - 1);
                        w_state_d = S_CLEAR;
                    end else begin
                        w_res_data_d = 32'h0;
                        w_state_d    = S_HOLD;
                    end
                end
            end
            S_CLEAR: begin
                if (r_tmr_q == '0) begin
                    w_state_d = S_FEED;
                end else begin
                    w_tmr_d = r_tmr_q - C_TMR_W'(1);
                end
            end
            S_FEED: begin
                if (w_hs) begin
                    w_mac_a_d = in_a;
                    w_mac_b_d = in_b;
                    w_cnt_d   = w_cnt_inc;
                    if (w_cnt_inc == r_len_q) begin
                        w_tmr_d   = C_TMR_W'(LATENCY);
                        w_state_d = S_DRAIN;
                    end
                end else if (r_bubbles_q != 16'hFFFF) begin
                    w_bubbles_d = r_bubbles_q + 16'd1;
                end
            end
            S_DRAIN: begin
                // the last pair's contribution reaches mac_out as the counter hits zero
                if (r_tmr_q == '0) begin
                    w_res_data_d = mac_out;
                    w_state_d    = S_HOLD;
                end else begin
                    w_tmr_d = r_tmr_q - C_TMR_W'(1);
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        w_res_valid_d = (w_state_d == S_HOLD);
        w_in_ready_d  = (w_state_d == S_FEED);
        w_busy_d      = (w_state_d != S_IDLE);
        w_clr_d       = (w_state_d == S_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q     <= S_IDLE;
            r_len_q       <= '0;
            r_cnt_q       <= '0;
            r_tmr_q       <= '0;
            r_mac_a_q     <= 32'h0;
            r_mac_b_q     <= 32'h0;
            r_res_data_q  <= 32'h0;
            r_res_valid_q <= 1'b0;
            r_in_ready_q  <= 1'b0;
            r_busy_q      <= 1'b0;
            r_clr_q       <= 1'b0;
            r_bubbles_q   <= 16'h0;
        end else begin
            r_state_q     <= w_state_d;
            r_len_q       <= w_len_d;
            r_cnt_q       <= w_cnt_d;
            r_tmr_q       <= w_tmr_d;
            r_mac_a_q     <= w_mac_a_d;
            r_mac_b_q     <= w_mac_b_d;
            r_res_data_q  <= w_res_data_d;
            r_res_valid_q <= w_res_valid_d;
            r_in_ready_q  <= w_in_ready_d;
            r_busy_q      <= w_busy_d;
            r_clr_q       <= w_clr_d;
            r_bubbles_q   <= w_bubbles_d;
        end
    end

    assign mac_clr   = reset | r_clr_q;
    assign mac_a     = r_mac_a_q;
    assign mac_b     = r_mac_b_q;
    assign res_data  = r_res_data_q;
    assign res_valid = r_res_valid_q;
    assign in_ready  = r_in_ready_q;
    assign busy      = r_busy_q;
    assign bubbles   = r_bubbles_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_mac_seq.sv
`default_nettype none
// =============================================================================
// Module      : tb_fp_mac_seq
// Description : Scoreboard bench for fp_mac_seq driving an integer-valued MAC model.
// Revision    : 1.0  initial release
// =============================================================================
module tb_fp_mac_seq;

    localparam int LEN_W      = 16;
    localparam int LATENCY    = 6;
    localparam int CLR_CYCLES = 2;
    localparam int MAXN       = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             in_valid;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic             in_ready;
    logic [31:0]      mac_a;
    logic [31:0]      mac_b;
    logic             mac_clr;
    logic [31:0]      mac_out;
    logic             res_valid;
    logic [31:0]      res_data;
    logic             res_ready;
    logic [15:0]      bubbles;

    fp_mac_seq #(
        .LEN_W      (LEN_W),
        .LATENCY    (LATENCY),
        .CLR_CYCLES (CLR_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ready  (in_ready),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_clr   (mac_clr),
        .mac_out   (mac_out),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .bubbles   (bubbles)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Operands are small integers, so single-precision encoding is exact.
    function automatic logic [31:0] i2f(input int v);
        int          mag;
        int          p;
        logic [31:0] m;
        if (v == 0) return 32'h0;
        mag = (v < 0) ? -v : v;
        p = 0;
        for (int i = 0; i < 31; i++) if (mag >= (1 << i)) p = i;
        m = 32'(mag) << (23 - p);
        return {(v < 0), 8'(127 + p), m[22:0]};
    endfunction

    function automatic int f2i(input logic [31:0] f);
        int e;
        int mag;
        e = int'(f[30:23]);
        if (e < 127) return 0;
        if (e > 150) e = 150;
        mag = int'({1'b1, f[22:0]} >> (150 - e));
        return f[31] ? -mag : mag;
    endfunction

    // MAC model: a product enters on the edge after it sits on mac_a/mac_b and
    // is added into the visible sum LATENCY edges after that.
    int pipe_q [LATENCY-1];
    int acc_q;
    always @(posedge clk) begin
        if (mac_clr) begin
            acc_q <= 0;
            for (int i = 0; i < LATENCY - 1; i++) pipe_q[i] <= 0;
        end else begin
            acc_q     <= acc_q + pipe_q[LATENCY-2];
            pipe_q[0] <= f2i(mac_a) * f2i(mac_b);
            for (int i = 1; i < LATENCY - 1; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end
    assign mac_out = i2f(acc_q);

    typedef struct {
        logic [31:0] data;
        int          rise;
        int          bub;
        bit          chk_bub;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   ea [MAXN];
    int   eb [MAXN];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : p_monitor
        bit          prev_rv;
        logic [31:0] prev_data;
        int          rise_cyc;
        exp_t        e;
        prev_rv   = 1'b0;
        prev_data = 32'h0;
        rise_cyc  = 0;
        forever begin
            @(negedge clk);
            if (res_valid && !prev_rv) rise_cyc = cyc;
            if (res_valid && prev_rv) chk("res_data_stable", res_data, prev_data);
            if (res_valid && res_ready && !reset) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_result: got %h, required no result", res_data);
                end else begin
                    e = sb.pop_front();
                    chk("res_data", res_data, e.data);
                    chk("res_valid_rise", 32'(rise_cyc), 32'(e.rise));
                    if (e.chk_bub) chk("bubbles", 32'(bubbles), 32'(e.bub));
                end
            end
            prev_rv   = res_valid;
            prev_data = res_data;
        end
    end

    task automatic wait_result(input int hold_n, input bit pulse_start);
        int guard;
        guard = 0;
        res_ready = (hold_n == 0);
        while (!res_valid && guard < 200) begin
            chk("in_ready_outside_feed", 32'(in_ready), 32'd0);
            chk("mac_clr_drain", 32'(mac_clr), 32'd0);
            in_valid = 1'b1;
            in_a     = i2f(5);
            in_b     = i2f(3);
            tick();
            guard++;
        end
        in_valid = 1'b0;
        if (!res_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL res_valid_timeout: got res_valid 0 after %0d cycles, required 1", guard);
            res_ready = 1'b1;
            return;
        end
        for (int i = 0; i < hold_n; i++) begin
            start = pulse_start && (i == 3);
            len   = LEN_W'(3);
            tick();
        end
        start     = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd0);
        chk("res_valid_after_accept", 32'(res_valid), 32'd0);
        chk("result_consumed", 32'(sb.size()), 32'd0);
        if (pulse_start) begin
            tick();
            chk("start_in_hold_ignored", 32'(busy), 32'd0);
        end
    endtask

    task automatic run_cmd(input int L, input int gap_at, input int gap_n,
                           input int hold_n, input bit pulse_start);
        int   s;
        int   idx;
        int   bub;
        int   last;
        int   first_rdy;
        int   guard;
        int   gap_left;
        int   sum;
        exp_t e;
        s   = cyc;
        sum = 0;
        for (int k = 0; k < L; k++) sum += ea[k] * eb[k];
        start = 1'b1;
        len   = LEN_W'(L);
        if (L == 0) begin
            e.data = 32'h0; e.rise = s + 1; e.bub = 0; e.chk_bub = 1'b0;
            sb.push_back(e);
            tick();
            start = 1'b0;
            chk("in_ready_len0", 32'(in_ready), 32'd0);
            chk("mac_clr_len0", 32'(mac_clr), 32'd0);
        end else begin
            tick();
            start = 1'b0;
            chk("busy_after_start", 32'(busy), 32'd1);
            idx = 0; bub = 0; last = 0; first_rdy = -1; guard = 0; gap_left = gap_n;
            while (idx < L && guard < 500) begin
                chk("mac_clr_window", 32'(mac_clr), 32'(cyc <= s + CLR_CYCLES));
                if (in_ready && idx == gap_at && gap_left > 0) begin
                    in_valid = 1'b0;
                    gap_left--;
                end else begin
                    in_valid = 1'b1;
                    in_a     = i2f(ea[idx]);
                    in_b     = i2f(eb[idx]);
                end
                if (in_ready) begin
                    if (first_rdy < 0) first_rdy = cyc;
                    if (in_valid) begin
                        idx++;
                        last = cyc;
                    end else begin
                        bub++;
                    end
                end
                tick();
                guard++;
            end
            if (idx < L) begin
                n_vec++;
                n_err++;
                $display("FAIL feed_timeout: got %0d handshakes, required %0d", idx, L);
            end
            chk("first_in_ready", 32'(first_rdy), 32'(s + CLR_CYCLES + 1));
            e.data = i2f(sum); e.rise = last + LATENCY + 2; e.bub = bub; e.chk_bub = 1'b1;
            sb.push_back(e);
        end
        wait_result(hold_n, pulse_start);
    endtask

    task automatic run_abort();
        int idx;
        int guard;
        start = 1'b1;
        len   = LEN_W'(4);
        tick();
        start = 1'b0;
        idx = 0; guard = 0;
        while (idx < 2 && guard < 100) begin
            in_valid = 1'b1;
            in_a     = i2f(9);
            in_b     = i2f(9);
            if (in_ready) idx++;
            tick();
            guard++;
        end
        reset = 1'b1;
        tick();
        chk("abort_res_valid", 32'(res_valid), 32'd0);
        chk("abort_mac_clr", 32'(mac_clr), 32'd1);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("abort_mac_clr_release", 32'(mac_clr), 32'd0);
    endtask

    initial begin : p_main
        int L;
        reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
        in_a = 32'h0; in_b = 32'h0; res_ready = 1'b0;
        repeat (3) tick();
        chk("reset_mac_clr", 32'(mac_clr), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_res_valid", 32'(res_valid), 32'd0);
        chk("reset_mac_a", mac_a, 32'h0);
        chk("reset_mac_b", mac_b, 32'h0);
        chk("reset_res_data", res_data, 32'h0);
        chk("reset_bubbles", 32'(bubbles), 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_mac_clr", 32'(mac_clr), 32'd0);

        ea[0] = 1; ea[1] = 2; ea[2] = 3; ea[3] = 4;
        for (int k = 0; k < 4; k++) eb[k] = 1;
        run_cmd(4, -1, 0, 0, 1'b0);
        run_cmd(4, 2, 3, 0, 1'b0);
        run_cmd(0, -1, 0, 0, 1'b0);

        ea[0] = 3; eb[0] = 2; ea[1] = 5; eb[1] = -1;
        run_cmd(2, -1, 0, 10, 1'b1);

        run_abort();
        ea[0] = 2; eb[0] = 3; ea[1] = 1; eb[1] = 1;
        run_cmd(2, -1, 0, 0, 1'b0);

        ea[0] = 2; eb[0] = 2;
        run_cmd(1, -1, 0, 0, 1'b0);
        run_cmd(1, -1, 0, 0, 1'b0);

        repeat (25) begin
            L = int'($urandom_range(12));
            for (int k = 0; k < L; k++) begin
                ea[k] = int'($urandom_range(16)) - 8;
                eb[k] = int'($urandom_range(16)) - 8;
            end
            run_cmd(L, (L > 0) ? int'($urandom_range(L - 1)) : 0,
                    int'($urandom_range(3)), int'($urandom_range(3)), 1'($urandom_range(1)));
        end

        repeat (5) tick();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : p_watchdog
        #400000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
